mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
Main control FSM for the multicycle MIPS core. Sequences fetch, decode, execute, memory and writeback over shared datapath resources: a single memory port, one ALU and the register file. Issues the 3-bit ALUOp consumed by the ALU decoder, and generates every datapath mux select and write enable. Stalls in memory states until the memory port signals ready.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  6  opcode field from the instruction register (IR[31:26]); stable from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory port completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  memory write strobe; qualified by mem_ready
- ir_write  out  1  instruction register load enable
- reg_write  out  1  register file write enable
- reg_dst  out  1  write-address select: 1 = rd, 0 = rt
- mem_to_reg  out  1  writeback select: 1 = memory data, 0 = ALUOut
- iord  out  1  memory address select: 1 = ALUOut, 0 = PC
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B select: 00 = B, 01 = const 4, 10 = immediate, 11 = immediate<<2
- zero_ext  out  1  immediate zero-extension (ori, xori)
- alu_op  out  3  ALUOp encoding, listed below
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_en  out  1  PC load enable
- illegal_op  out  1  sticky flag for an undecoded opcode
- state  out  4  current state, for debug

Behaviour:
- Opcodes:
  - R-type 000000, lw 100011, sw 101011
  - beq 000100, bne 000101, j 000010
  - addi 001000, slti 001010, ori 001101, xori 001110
- ALUOp encoding:
  - 000 add, 001 sub (beq), 010 decode by funct, 011 slt
  - 100 sub (bne), 110 or, 111 xor
- Output model: Moore decode from the state register, except that mem_ready gates the FETCH/MEMRD/MEMWR enables and zero feeds pc_en. Every output not listed for a state is 0 in that state.
- States and outputs:
  - FETCH(0): mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00; ir_write=pc_en=mem_ready. Holds until mem_ready, then goes to DECODE.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=000 (branch target into ALUOut).
    - lw/sw go to MEMADR; R-type goes to RTYPEEX; beq goes to BEQ; bne goes to BNE; j goes to JUMP; addi/slti/ori/xori go to IMMEX.
    - Any other opcode sets illegal_op and goes to FETCH.
  - MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=000. lw goes to MEMRD; sw goes to MEMWR.
  - MEMRD(3): mem_req=1, iord=1. Holds until mem_ready, then goes to MEMWB.
  - MEMWB(4): reg_write=1, reg_dst=0, mem_to_reg=1. Goes to FETCH.
  - MEMWR(5): mem_req=1, iord=1, mem_write=mem_ready. Holds until mem_ready, then goes to FETCH.
  - RTYPEEX(6): alu_src_a=1, alu_src_b=00, alu_op=010. Goes to ALUWB.
  - ALUWB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Goes to FETCH.
  - BEQ(8): alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=01, pc_en=zero. Goes to FETCH.
  - BNE(12): as BEQ but alu_op=100, pc_en=~zero. Goes to FETCH.
  - IMMEX(9): alu_src_a=1, alu_src_b=10.
    - alu_op: addi 000, slti 011, ori 110, xori 111.
    - zero_ext=1 for ori/xori only.
    - Goes to IMMWB.
  - IMMWB(10): reg_write=1, reg_dst=0, mem_to_reg=0. Goes to FETCH.
  - JUMP(11): pc_src=10, pc_en=1. Goes to FETCH.
  - Codes 13–15 are unreachable; if entered, all outputs are 0 and the next state is FETCH.
- Instruction latency with mem_ready tied high:
  - lw 5 cycles
  - sw 4 cycles
  - R-type and immediate ops 4 cycles
  - beq, bne and j 3 cycles
- Each cycle mem_ready is low in FETCH/MEMRD/MEMWR adds one cycle. The state holds and all enables other than mem_req stay 0.
- Reset (low, at any time, including mid-access): state=FETCH immediately and illegal_op=0. While reset is asserted, all outputs follow FETCH decode, with ir_write, pc_en and mem_write forced to 0.
- illegal_op is cleared only by reset.
- At most one of reg_write, mem_write and ir_write is asserted in any cycle.

Test Plan:
- Reset released, mem_ready=1, op=100011 (lw) -> states 0,1,2,3,4,0. reg_write=1 only in state 4, with mem_to_reg=1 and reg_dst=0.
- op=000101 (bne), zero=0 in state 12 -> pc_en=1, pc_src=01, alu_op=100. Repeat with zero=1 -> pc_en=0.
- op=001101 (ori) -> IMMEX drives alu_op=110, zero_ext=1, alu_src_b=10. Then IMMWB drives reg_write=1, reg_dst=0.
- sw with mem_ready held low for 3 cycles in MEMWR -> state stays 5 for 4 cycles and mem_write is high only in the final cycle. Same with 2 stall cycles in FETCH -> ir_write pulses exactly once.
- op=111111 -> DECODE returns to FETCH with illegal_op=1. A following valid R-type runs normally and illegal_op stays 1 until reset.
- Reset asserted in MEMRD while mem_ready=0 -> asynchronous return to state 0, ir_write=pc_en=mem_write=0 during reset, and a clean fetch after release.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and write enable; memory states hold until mem_ready.
module mips_multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       iord,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       zero_ext,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);
  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BEQ     = 4'd8;
  localparam logic [3:0] S_IMMEX   = 4'd9;
  localparam logic [3:0] S_IMMWB   = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;
  localparam logic [3:0] S_BNE     = 4'd12;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       r_illegal;
  logic       w_dec_illegal;
  logic       w_mem_go;

  // Enables that complete a memory access are also suppressed while reset is held.
  assign w_mem_go   = mem_ready & reset;
  assign state      = r_state;
  assign illegal_op = r_illegal;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= RESET_STATE;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_dec_illegal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next        = S_FETCH;
    w_dec_illegal = 1'b0;
    case (r_state)
      S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:                        w_next = S_MEMADR;
          OP_R:                                w_next = S_RTYPEEX;
          OP_BEQ:                              w_next = S_BEQ;
          OP_BNE:                              w_next = S_BNE;
          OP_J:                                w_next = S_JUMP;
          OP_ADDI, OP_SLTI, OP_ORI, OP_XORI:   w_next = S_IMMEX;
          default: begin
            w_next        = S_FETCH;
            w_dec_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:  w_next = (op == OP_LW) ? S_MEMRD : ((op == OP_SW) ? S_MEMWR : S_FETCH);
      S_MEMRD:   w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: w_next = S_ALUWB;
      S_IMMEX:   w_next = S_IMMWB;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    iord       = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    zero_ext   = 1'b0;
    alu_op     = 3'b000;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = w_mem_go;
        pc_en     = w_mem_go;
      end
      S_DECODE:  alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_write = w_mem_go;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BEQ, S_BNE: begin
        alu_src_a = 1'b1;
        alu_op    = (r_state == S_BNE) ? 3'b100 : 3'b001;
        pc_src    = 2'b01;
        pc_en     = (r_state == S_BNE) ? ~zero : zero;
      end
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op)
          OP_SLTI: alu_op = 3'b011;
          OP_ORI:  alu_op = 3'b110;
          OP_XORI: alu_op = 3'b111;
          default: alu_op = 3'b000;
        endcase
        zero_ext = (op == OP_ORI) || (op == OP_XORI);
      end
      S_IMMWB:   reg_write = 1'b1;
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench: instruction-level path model plus per-state output table, checked every cycle.
module tb_mips_multicycle_ctrl;
  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
  } outs_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, JMP = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000, SLTI = 6'b001010, ORI = 6'b001101, XORI = 6'b001110;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, iord, alu_src_a;
  logic [1:0] alu_src_b;
  logic       zero_ext;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic       pc_en, illegal_op;
  logic [3:0] state;

  mips_multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .iord(iord), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .zero_ext(zero_ext), .alu_op(alu_op), .pc_src(pc_src),
    .pc_en(pc_en), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         n_steps = 0;
  logic       chk = 1'b0;
  logic [3:0] exp_state = 4'd0;
  logic       exp_ill = 1'b0;
  int         st_cnt [16];
  outs_t      snap [16];
  int         mw_cnt = 0;
  int         ir_cnt = 0;
  outs_t      act_o, exp_o;

  function automatic logic legal(input logic [5:0] o);
    return o inside {LW, SW, RT, BEQ, BNE, JMP, ADDI, SLTI, ORI, XORI};
  endfunction

  // What each state must present, straight from the state/output table.
  function automatic outs_t model(input logic [3:0] s, input logic [5:0] o, input logic z,
                                  input logic mr, input logic rn);
    outs_t e;
    e = '0;
    case (s)
      4'd0:  begin e.mem_req = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_en = mr; end
      4'd1:  e.alu_src_b = 2'b11;
      4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      4'd3:  begin e.mem_req = 1; e.iord = 1; end
      4'd4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
      4'd5:  begin e.mem_req = 1; e.iord = 1; e.mem_write = mr; end
      4'd6:  begin e.alu_src_a = 1; e.alu_op = 3'b010; end
      4'd7:  begin e.reg_write = 1; e.reg_dst = 1; end
      4'd8:  begin e.alu_src_a = 1; e.alu_op = 3'b001; e.pc_src = 2'b01; e.pc_en = z; end
      4'd12: begin e.alu_src_a = 1; e.alu_op = 3'b100; e.pc_src = 2'b01; e.pc_en = !z; end
      4'd9: begin
        e.alu_src_a = 1; e.alu_src_b = 2'b10;
        e.alu_op = (o == SLTI) ? 3'b011 : (o == ORI) ? 3'b110 : (o == XORI) ? 3'b111 : 3'b000;
        e.zero_ext = (o == ORI || o == XORI);
      end
      4'd10: e.reg_write = 1;
      4'd11: begin e.pc_src = 2'b10; e.pc_en = 1; end
      default: ;
    endcase
    if (!rn) begin e.ir_write = 0; e.pc_en = 0; e.mem_write = 0; end
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk) begin
      act_o = '{mem_req, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, iord, alu_src_a,
                alu_src_b, zero_ext, alu_op, pc_src, pc_en};
      exp_o = model(exp_state, op, zero, mem_ready, reset);
      n_cmp++;
      if (state !== exp_state) begin
        n_fail++;
        $display("FAIL state @%0t: got %0d expected %0d", $time, state, exp_state);
      end
      n_cmp++;
      if (act_o !== exp_o || illegal_op !== (reset ? exp_ill : 1'b0)) begin
        n_fail++;
        $display("FAIL outputs @%0t state %0d: got %h ill=%b expected %h ill=%b",
                 $time, exp_state, act_o, illegal_op, exp_o, reset ? exp_ill : 1'b0);
      end
      st_cnt[state]++;
      snap[state] = act_o;
      if (mem_write) mw_cnt++;
      if (ir_write) ir_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: drive inputs, publish the expected state, then advance past the edge.
  task automatic step(input logic [3:0] s, input logic mr);
    mem_ready = mr;
    exp_state = s;
    @(posedge clk);
    if (!reset) exp_ill = 1'b0;
    else if (s == 4'd1 && !legal(op)) exp_ill = 1'b1;
    #1;
    n_steps++;
  endtask

  // Expected state path of one instruction, with stall cycles inserted.
  task automatic run(input logic [5:0] o, input logic z, input int fst, input int mst);
    op = o;
    zero = z;
    n_steps = 0;
    repeat (fst) step(4'd0, 1'b0);
    step(4'd0, 1'b1);
    step(4'd1, 1'b1);
    case (o)
      LW: begin
        step(4'd2, 1'b1);
        repeat (mst) step(4'd3, 1'b0);
        step(4'd3, 1'b1);
        step(4'd4, 1'b1);
      end
      SW: begin
        step(4'd2, 1'b1);
        repeat (mst) step(4'd5, 1'b0);
        step(4'd5, 1'b1);
      end
      RT:                     begin step(4'd6, 1'b1); step(4'd7, 1'b1); end
      BEQ:                    step(4'd8, 1'b1);
      BNE:                    step(4'd12, 1'b1);
      JMP:                    step(4'd11, 1'b1);
      ADDI, SLTI, ORI, XORI:  begin step(4'd9, 1'b1); step(4'd10, 1'b1); end
      default: ;
    endcase
  endtask

  int mw0, ir0, s50;

  initial begin
    for (int i = 0; i < 16; i++) begin st_cnt[i] = 0; snap[i] = '0; end
    reset = 1'b0; op = LW; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk = 1'b1;
    step(4'd0, 1'b1);
    step(4'd0, 1'b1);
    reset = 1'b1;

    run(LW, 1'b0, 0, 0);
    check("lw_latency", n_steps, 5);
    check("lw_wb_reg_write", snap[4].reg_write, 1);
    check("lw_wb_mem_to_reg", snap[4].mem_to_reg, 1);
    check("lw_wb_reg_dst", snap[4].reg_dst, 0);

    run(BNE, 1'b0, 0, 0);
    check("bne_taken_pc_en", snap[12].pc_en, 1);
    check("bne_pc_src", snap[12].pc_src, 1);
    check("bne_alu_op", snap[12].alu_op, 4);
    check("bne_latency", n_steps, 3);
    run(BNE, 1'b1, 0, 0);
    check("bne_not_taken_pc_en", snap[12].pc_en, 0);

    run(ORI, 1'b0, 0, 0);
    check("ori_alu_op", snap[9].alu_op, 6);
    check("ori_zero_ext", snap[9].zero_ext, 1);
    check("ori_alu_src_b", snap[9].alu_src_b, 2);
    check("ori_wb_reg_write", snap[10].reg_write, 1);
    check("ori_wb_reg_dst", snap[10].reg_dst, 0);

    mw0 = mw_cnt; s50 = st_cnt[5];
    run(SW, 1'b0, 0, 3);
    check("sw_stall_state5_cycles", st_cnt[5] - s50, 4);
    check("sw_stall_mem_write_cycles", mw_cnt - mw0, 1);
    ir0 = ir_cnt;
    run(SW, 1'b0, 2, 0);
    check("fetch_stall_ir_write_pulses", ir_cnt - ir0, 1);
    check("fetch_stall_state0_then_decode", n_steps, 6);

    run(6'b111111, 1'b0, 0, 0);
    check("illegal_set", illegal_op, 1);
    run(RT, 1'b0, 0, 0);
    check("illegal_sticky_after_rtype", illegal_op, 1);
    run(BEQ, 1'b1, 0, 0);
    run(BEQ, 1'b0, 0, 0);
    run(JMP, 1'b0, 0, 0);
    run(ADDI, 1'b0, 1, 0);
    run(SLTI, 1'b0, 0, 0);
    run(XORI, 1'b1, 0, 0);
    run(LW, 1'b0, 1, 2);

    // Abort a load mid-access with reset while memory is still busy.
    op = LW;
    step(4'd0, 1'b1);
    step(4'd1, 1'b1);
    step(4'd2, 1'b1);
    step(4'd3, 1'b0);
    step(4'd3, 1'b0);
    #2;
    reset = 1'b0;
    exp_state = 4'd0;
    exp_ill = 1'b0;
    #1;
    check("async_reset_state", state, 0);
    check("async_reset_ir_write", ir_write, 0);
    check("async_reset_pc_en", pc_en, 0);
    check("async_reset_mem_write", mem_write, 0);
    check("async_reset_illegal", illegal_op, 0);
    check("async_reset_mem_req", mem_req, 1);
    @(posedge clk);
    #1;
    step(4'd0, 1'b1);
    reset = 1'b1;
    run(LW, 1'b0, 0, 0);
    run(RT, 1'b0, 0, 0);
    check("rtype_latency", n_steps, 4);
    step(4'd0, 1'b0);
    chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
